i2c_master_ctrl: RTL and testbench
==================================

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 Parameter QTR, default 250: quarter-bit period in clk cycles; legal range 1..65535.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accept; a command is taken on a cycle where cmd_valid and cmd_ready are both high.
REQ-006 cmd_rw  in  1  0 = write, 1 = read.
REQ-007 cmd_addr  in  7  target slave address.
REQ-008 cmd_data  in  8  write byte; ignored for reads.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_data  out  8  read byte; 0x00 after writes.
REQ-011 rsp_nack  out  1  the slave NACKed the address or the write data; valid with rsp_valid.
REQ-012 busy  out  1  high whenever the block is not in IDLE.
REQ-013 i_scl, i_sda  in  1 each  sampled bus lines.
REQ-014 o_scl, o_sda  out  1 each  constant 0 (open-drain data value).
REQ-015 o_scl_en, o_sda_en  out  1 each  1 = pull the line low, 0 = release it.

Function
REQ-016 States: IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP.
REQ-017 Each bit slot is 4 phases of QTR cycles each:
- P0: SCL low; SDA changes at the start of P0.
- P1: SCL low.
- P2: SCL released.
- P3: SCL released; SDA is sampled on the first cycle of P3.
REQ-018 A command is accepted only in IDLE (cmd_ready=1), and the address, rw and data are registered at acceptance. START P0 begins the following cycle.
REQ-019 START slot: SDA released in P0–P1 and pulled low in P2–P3, so SDA falls while SCL is high.
REQ-020 ADDR: 8 slots, sent MSB first: cmd_addr[6:0] followed by cmd_rw. ADDR_ACK is the 9th slot: SDA released, ACK sampled.
REQ-021 Write: WR_DATA sends 8 slots MSB first, then WR_ACK samples the slave's ACK. Read: RD_DATA releases SDA for 8 slots and shifts in i_sda MSB first. RD_ACK then releases SDA, giving a master NACK (single-byte read).
REQ-022 STOP slot: SDA pulled low in P0–P1 and released in P2–P3, so SDA rises while SCL is high.
REQ-023 A sampled 1 in ADDR_ACK skips the data phase, goes to STOP and reports rsp_nack=1. A sampled 1 in WR_ACK goes to STOP and reports rsp_nack=1.
REQ-024 Transaction length:
- full transaction: 20 slots (80·QTR cycles);
- address NACK: 11 slots (44·QTR cycles).
REQ-025 On the cycle after STOP P3 ends:
- rsp_valid pulses for 1 cycle;
- the state returns to IDLE and cmd_ready=1 on the same cycle;
- rsp_data and rsp_nack hold until the next response.
REQ-026 cmd_valid while busy is ignored and is not queued.
REQ-027 The quarter counter wraps from QTR-1 to 0 on each phase advance. The bit counter is 3 bits, counts 7 down to 0, and wraps only on a state change.

Reset
REQ-028 On rst, the following take effect on the next edge:
- state = IDLE;
- o_scl_en = o_sda_en = 0 (bus released);
- cmd_ready = 1, busy = 0, rsp_valid = 0, rsp_data = 0x00, rsp_nack = 0;
- all counters cleared.
REQ-029 A reset in mid-transaction releases the bus immediately, without generating a STOP or issuing a response.
REQ-030 rst has priority over a simultaneous cmd_valid.

Configuration
REQ-031 Macro I2C_CLK_STRETCH_EN:
- Defined: the quarter counter holds in P2 until i_scl reads 1, so a slave may stretch the clock.
- Undefined: i_scl is ignored and timing is fixed.

Structure
REQ-032 Package i2c_pkg holds:
- the state enum;
- the command struct {rw, addr, data};
- localparams for slot phase count (4) and byte width (8).
REQ-033 Sub-module i2c_phase_timer generates the quarter and phase counts, with a hold input for stretching. It is instantiated once.

Verification
REQ-034 QTR=2, write addr 0x50 data 0xA5, slave ACKs:
- SDA shows START, bits 1010000 0, ACK, 10100101, ACK, STOP;
- rsp_valid occurs 160 cycles after acceptance with rsp_nack=0.
REQ-035 Read addr 0x50, slave drives 0x3C: rsp_data=0x3C, master releases SDA in the 9th slot, rsp_nack=0.
REQ-036 Address with no ACK (i_sda held 1): no data slots, STOP, rsp_nack=1, rsp_valid 88 cycles after acceptance at QTR=2.
REQ-037 rst asserted during data bit 3: both en outputs are 0 and cmd_ready=1 on the next cycle, and no rsp_valid follows.
REQ-038 cmd_valid pulsed while busy: ignored, with exactly one rsp_valid for the original command.
REQ-039 With I2C_CLK_STRETCH_EN, i_scl held low 10 cycles in ADDR P2: the transaction lengthens by exactly 10 cycles and the data is unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the single-byte I2C master controller.
//   i2c_state_e : controller state encoding
//   i2c_cmd_t   : command captured at acceptance {rw, addr, data}
//   SLOT_PHASES : number of quarter phases in one bit slot
//   BYTE_W      : width of a data byte on the bus
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam int SLOT_PHASES = 4;
    localparam int BYTE_W      = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_STOP
    } i2c_state_e;

    typedef struct packed {
        logic              rw;
        logic [6:0]        addr;
        logic [BYTE_W-1:0] data;
    } i2c_cmd_t;

endpackage

// File: rtl/i2c_phase_timer.sv
// ---------------------------------------------------------------------------
// i2c_phase_timer
// Divides each bit slot into SLOT_PHASES phases of QTR clk cycles.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   run        : counters advance while high, are held at zero while low
//   hold       : freezes the quarter counter (slave clock stretching)
//   phase      : current phase within the slot (0..3)
//   phase_end  : last cycle of the current phase (counter will wrap)
//   slot_end   : last cycle of phase 3, i.e. of the whole slot
//   sample_pt  : first cycle of phase 3, where SDA is sampled
// ---------------------------------------------------------------------------
module i2c_phase_timer
    import i2c_pkg::*;
#(
    parameter int QTR = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       hold,
    output logic [1:0] phase,
    output logic       phase_end,
    output logic       slot_end,
    output logic       sample_pt
);

    localparam logic [15:0] QTR_LAST   = 16'(QTR - 1);
    localparam logic [1:0]  PHASE_LAST = 2'(SLOT_PHASES - 1);

    logic [15:0] qtr_q, qtr_d;
    logic [1:0]  phase_q, phase_d;

    // The phase counter wraps 3 -> 0 by plain 2-bit overflow, so a new slot
    // starts automatically without any extra bookkeeping.
    always_comb begin
        qtr_d   = qtr_q;
        phase_d = phase_q;
        if (!run) begin
            qtr_d   = '0;
            phase_d = '0;
        end else if (!hold) begin
            if (qtr_q == QTR_LAST) begin
                qtr_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                qtr_d = qtr_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qtr_q   <= '0;
            phase_q <= '0;
        end else begin
            qtr_q   <= qtr_d;
            phase_q <= phase_d;
        end
    end

    assign phase     = phase_q;
    assign phase_end = run && !hold && (qtr_q == QTR_LAST);
    assign slot_end  = phase_end && (phase_q == PHASE_LAST);
    assign sample_pt = run && (phase_q == PHASE_LAST) && (qtr_q == '0);

endmodule

// File: rtl/i2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_master_ctrl
// Single-byte I2C master: START, 7-bit address + R/W, one data byte
// (write with slave ACK check, or read ending with a master NACK), STOP.
// Ports:
//   clk, rst                 : system clock, synchronous active-high reset
//   cmd_valid/cmd_ready      : command handshake, accepted only in IDLE
//   cmd_rw, cmd_addr, cmd_data : command fields (data ignored for reads)
//   rsp_valid                : one-cycle completion pulse
//   rsp_data, rsp_nack       : read byte (0 after writes) and NACK flag
//   busy                     : high whenever not IDLE
//   i_scl, i_sda             : sampled bus lines
//   o_scl, o_sda             : constant 0 (open-drain data value)
//   o_scl_en, o_sda_en       : 1 pulls the line low, 0 releases it
// Configuration:
//   I2C_CLK_STRETCH_EN : when defined, phase 2 is held until i_scl reads 1
// ---------------------------------------------------------------------------
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int QTR = 250
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [6:0]        cmd_addr,
    input  logic [BYTE_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [BYTE_W-1:0] rsp_data,
    output logic              rsp_nack,
    output logic              busy,
    input  logic              i_scl,
    input  logic              i_sda,
    output logic              o_scl,
    output logic              o_sda,
    output logic              o_scl_en,
    output logic              o_sda_en
);

`ifdef I2C_CLK_STRETCH_EN
    localparam bit STRETCH_EN = 1'b1;
`else
    localparam bit STRETCH_EN = 1'b0;
`endif

    i2c_state_e        state_q, state_d;
    i2c_cmd_t          cmd_q, cmd_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              nack_q, nack_d;
    logic              smp_q, smp_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [BYTE_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_nack_q, rsp_nack_d;

    logic [1:0]        phase;
    logic              phase_end;
    logic              slot_end;
    logic              sample_pt;
    logic              run;
    logic              stretch_hold;
    logic              sda_now;
    logic [BYTE_W-1:0] addr_byte;
    logic              scl_en;
    logic              sda_en;

    assign run          = (state_q != ST_IDLE);
    assign stretch_hold = STRETCH_EN && (phase == 2'd2) && !i_scl;

    i2c_phase_timer #(.QTR(QTR)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .hold      (stretch_hold),
        .phase     (phase),
        .phase_end (phase_end),
        .slot_end  (slot_end),
        .sample_pt (sample_pt)
    );

    // With QTR=1 the sample cycle is also the slot's last cycle, so the
    // ACK decision must see the live sample rather than the stored one.
    assign sda_now   = sample_pt ? i_sda : smp_q;
    assign addr_byte = {cmd_q.addr, cmd_q.rw};

    // Next-state and bus drive. SCL is pulled low in phases 0-1 of every
    // slot; SDA is set per state and held for the whole slot except in
    // START/STOP, where it toggles at phase 2 while SCL is high. The bit
    // counter decrements at each data-slot end, so its 0 -> 7 wrap always
    // coincides with leaving that state.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        nack_d      = nack_q;
        smp_d       = sda_now;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_nack_d  = rsp_nack_q;
        scl_en      = run && (phase < 2'd2);
        sda_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d    = ST_START;
                    cmd_d.rw   = cmd_rw;
                    cmd_d.addr = cmd_addr;
                    cmd_d.data = cmd_data;
                    bit_d      = 3'd7;
                    shift_d    = '0;
                    nack_d     = 1'b0;
                end
            end
            ST_START: begin
                sda_en = phase[1];
                if (slot_end) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                sda_en = ~addr_byte[bit_q];
                if (slot_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = ST_ADDR_ACK;
                end
            end
            ST_ADDR_ACK: begin
                if (slot_end) begin
                    if (sda_now) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        state_d = cmd_q.rw ? ST_RD_DATA : ST_WR_DATA;
                    end
                end
            end
            ST_WR_DATA: begin
                sda_en = ~cmd_q.data[bit_q];
                if (slot_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = ST_WR_ACK;
                end
            end
            ST_WR_ACK: begin
                if (slot_end) begin
                    nack_d  = sda_now;
                    state_d = ST_STOP;
                end
            end
            ST_RD_DATA: begin
                if (sample_pt) shift_d = {shift_q[BYTE_W-2:0], i_sda};
                if (slot_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = ST_RD_ACK;
                end
            end
            ST_RD_ACK: begin
                if (slot_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                sda_en = ~phase[1];
                if (slot_end) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = cmd_q.rw ? shift_q : '0;
                    rsp_nack_d  = nack_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            bit_q       <= 3'd7;
            shift_q     <= '0;
            nack_q      <= 1'b0;
            smp_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_nack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            nack_q      <= nack_d;
            smp_q       <= smp_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_nack_q  <= rsp_nack_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = run;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_nack  = rsp_nack_q;
    assign o_scl     = 1'b0;
    assign o_sda     = 1'b0;
    assign o_scl_en  = scl_en;
    assign o_sda_en  = sda_en;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_ctrl
// Directed bench for i2c_master_ctrl at QTR=2. A timing-driven slave model
// acknowledges or drives read data slot by slot, and the bus lines are
// recorded in phases 1 and 3 of each slot and compared against the bit
// pattern expected for the command.
// ---------------------------------------------------------------------------
module tb_i2c_master_ctrl;

    localparam int QTR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       busy;
    logic       i_scl;
    logic       i_sda;
    logic       o_scl;
    logic       o_sda;
    logic       o_scl_en;
    logic       o_sda_en;

    logic       slave_pull = 1'b0;
    logic       scl_force_low = 1'b0;

    int assert_count = 0;
    int fail_count   = 0;
    int rsp_count    = 0;

    i2c_master_ctrl #(.QTR(QTR)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .i_scl     (i_scl),
        .i_sda     (i_sda),
        .o_scl     (o_scl),
        .o_sda     (o_sda),
        .o_scl_en  (o_scl_en),
        .o_sda_en  (o_sda_en)
    );

    // Wired-AND open-drain bus: either side may pull a line low.
    assign i_sda = ~o_sda_en & ~slave_pull;
    assign i_scl = ~o_scl_en & ~scl_force_low;

    // Free-running system clock.
    always #5 clk = ~clk;

    // Count every completion pulse so stray or missing responses show up.
    always @(negedge clk) begin
        if (rsp_valid) rsp_count++;
    end

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one command, then scramble the inputs so the DUT must have
    // registered them at acceptance. Returns #1 after the accepting edge.
    task automatic applyStimulus(input bit rw, input logic [6:0] addr, input logic [7:0] data);
        int waited = 0;
        while (!cmd_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("ready before command", cmd_ready, 1'b1);
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_rw    = ~rw;
        cmd_addr  = ~addr;
        cmd_data  = ~data;
    endtask

    // Runs one transaction slot by slot. rst_slot >= 0 aborts with a reset in
    // that slot; poke pulses cmd_valid in slot 5; stretch holds SCL low at
    // the start of the first address bit's phase 2.
    task automatic runTxn(input string name, input bit rw, input logic [6:0] addr, input logic [7:0] data,
                          input bit ack_addr, input bit ack_data, input logic [7:0] rd_byte,
                          input int rst_slot, input bit poke, input int stretch);
        logic [7:0]  abyte;
        logic [19:0] exp_p1, exp_p3, pull, mask;
        logic [19:0] got_p1, got_p3, got_scl1, got_scl3;
        int          nslots;
        int          rsp_before;
        bit          exp_nack;
        logic [7:0]  exp_data;

        abyte    = {addr, rw};
        nslots   = ack_addr ? 20 : 11;
        exp_nack = !ack_addr || (!rw && !ack_data);
        exp_data = (rw && ack_addr) ? rd_byte : 8'h00;
        exp_p1 = '0; exp_p3 = '0; pull = '0; mask = '0;
        got_p1 = '0; got_p3 = '0; got_scl1 = '0; got_scl3 = '0;

        // Expected SDA line per slot, and what the slave drives.
        for (int s = 0; s < nslots; s++) begin
            mask[s] = 1'b1;
            if (s == 0) begin
                exp_p1[s] = 1'b1; exp_p3[s] = 1'b0;
            end else if (s <= 8) begin
                exp_p1[s] = abyte[8-s]; exp_p3[s] = abyte[8-s];
            end else if (s == 9) begin
                pull[s] = ack_addr; exp_p1[s] = !ack_addr; exp_p3[s] = !ack_addr;
            end else if (s == nslots - 1) begin
                exp_p1[s] = 1'b0; exp_p3[s] = 1'b1;
            end else if (s <= 17) begin
                if (rw) begin
                    pull[s] = !rd_byte[17-s];
                    exp_p1[s] = rd_byte[17-s]; exp_p3[s] = rd_byte[17-s];
                end else begin
                    exp_p1[s] = data[17-s]; exp_p3[s] = data[17-s];
                end
            end else begin
                pull[s]   = rw ? 1'b0 : ack_data;
                exp_p1[s] = rw ? 1'b1 : !ack_data;
                exp_p3[s] = rw ? 1'b1 : !ack_data;
            end
        end

        rsp_before = rsp_count;
        applyStimulus(rw, addr, data);
        checkOutput({name, " busy after accept"}, busy, 1'b1);

        for (int s = 0; s < nslots; s++) begin
            for (int p = 0; p < 4; p++) begin
                for (int c = 0; c < QTR; c++) begin
                    if (p == 0 && c == 0) slave_pull = pull[s];
                    cmd_valid = poke && s == 5 && p == 0 && c == 0;
                    if (cmd_valid) checkOutput({name, " ready while busy"}, cmd_ready, 1'b0);
                    if (s == rst_slot && p == 1 && c == 0) begin
                        checkOutput({name, " master drives data bit 3"}, o_sda_en, 1'b1);
                        rst = 1'b1;
                        @(posedge clk); #1;
                        rst = 1'b0;
                        slave_pull = 1'b0;
                        checkOutput({name, " scl_en after rst"}, o_scl_en, 1'b0);
                        checkOutput({name, " sda_en after rst"}, o_sda_en, 1'b0);
                        checkOutput({name, " ready after rst"}, cmd_ready, 1'b1);
                        checkOutput({name, " busy after rst"}, busy, 1'b0);
                        checkOutput({name, " rsp_data after rst"}, rsp_data, 8'h00);
                        checkOutput({name, " rsp_nack after rst"}, rsp_nack, 1'b0);
                        repeat (200) @(posedge clk);
                        #1;
                        checkOutput({name, " no response after rst"}, rsp_count, rsp_before);
                        return;
                    end
                    if (stretch > 0 && s == 1 && p == 2 && c == 0) begin
                        scl_force_low = 1'b1;
                        repeat (stretch) begin
                            @(posedge clk); #1;
                        end
                        scl_force_low = 1'b0;
                    end
                    if (p == 1 && c == 0) begin
                        got_p1[s] = i_sda; got_scl1[s] = i_scl;
                    end
                    if (p == 3 && c == 0) begin
                        got_p3[s] = i_sda; got_scl3[s] = i_scl;
                    end
                    @(posedge clk); #1;
                end
            end
        end
        cmd_valid  = 1'b0;
        slave_pull = 1'b0;

        checkOutput({name, " sda phase1"}, got_p1, exp_p1);
        checkOutput({name, " sda phase3"}, got_p3, exp_p3);
        checkOutput({name, " scl phase1"}, got_scl1, 20'h0);
        checkOutput({name, " scl phase3"}, got_scl3, mask);
        checkOutput({name, " rsp_valid on time"}, rsp_valid, 1'b1);
        checkOutput({name, " rsp_nack"}, rsp_nack, exp_nack);
        checkOutput({name, " rsp_data"}, rsp_data, exp_data);
        checkOutput({name, " ready at response"}, cmd_ready, 1'b1);
        checkOutput({name, " busy at response"}, busy, 1'b0);
        @(posedge clk); #1;
        checkOutput({name, " rsp_valid one cycle"}, rsp_valid, 1'b0);
        checkOutput({name, " rsp_data holds"}, rsp_data, exp_data);
        checkOutput({name, " response count"}, rsp_count, rsp_before + 1);
        if (poke) begin
            repeat (100) @(posedge clk);
            #1;
            checkOutput({name, " poke not queued"}, rsp_count, rsp_before + 1);
            checkOutput({name, " idle after poke"}, busy, 1'b0);
        end
    endtask

    // Main sequence: reset, then directed transactions.
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset scl_en", o_scl_en, 1'b0);
        checkOutput("reset sda_en", o_sda_en, 1'b0);
        checkOutput("reset ready", cmd_ready, 1'b1);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset rsp_data", rsp_data, 8'h00);
        checkOutput("reset rsp_nack", rsp_nack, 1'b0);
        checkOutput("reset o_scl/o_sda", {o_scl, o_sda}, 2'b00);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        runTxn("write 50/A5",    1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, -1, 1'b0, 0);
        runTxn("read 50/3C",     1'b1, 7'h50, 8'h00, 1'b1, 1'b1, 8'h3C, -1, 1'b0, 0);
        runTxn("reset mid-write", 1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, 14, 1'b0, 0);
        runTxn("addr nack",      1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 8'h00, -1, 1'b0, 0);
        runTxn("data nack",      1'b0, 7'h2A, 8'h0F, 1'b1, 1'b0, 8'h00, -1, 1'b0, 0);
        runTxn("read 7F/C3",     1'b1, 7'h7F, 8'h00, 1'b1, 1'b1, 8'hC3, -1, 1'b0, 0);
        runTxn("busy poke",      1'b0, 7'h13, 8'hC3, 1'b1, 1'b1, 8'h00, -1, 1'b1, 0);
`ifdef I2C_CLK_STRETCH_EN
        runTxn("stretch write",  1'b0, 7'h50, 8'hA5, 1'b1, 1'b1, 8'h00, -1, 1'b0, 10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    // Hard time limit in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
